decode_stage: RTL



---
 rtl/rv_pkg.sv | 47 ++++
 rtl/decode_stage_imm_gen.sv | 34 +++
 rtl/decode_stage.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_pkg
// Description : Shared RV32/RV64 opcodes, writeback codes and ID/EX control.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC  = 2'd3;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic       op1_src;
        logic       op2_src;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] wb_src;
        logic       reg_we;
        logic       illegal;
    } idex_ctrl_t;

    // Control word of a bubble; matches the decode of the canonical NOP.
    localparam idex_ctrl_t CTRL_BUBBLE = '{
        op1_src:   1'b0,
        op2_src:   1'b1,
        mem_read:  1'b0,
        mem_write: 1'b0,
        wb_src:    WB_ALU,
        reg_we:    1'b0,
        illegal:   1'b0
    };

endpackage
`default_nettype wire

// File: rtl/decode_stage_imm_gen.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen
// Description : Combinational immediate extraction, sign-extended to XLEN.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm
);

    logic [31:0] w_imm32;

    always_comb begin
        w_imm32 = {{20{instr[31]}}, instr[31:20]};
        case (instr[6:0])
            OP_S:             w_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_B:             w_imm32 = {{19{instr[31]}}, instr[31], instr[7],
                                         instr[30:25], instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC: w_imm32 = {instr[31:12], 12'b0};
            OP_JAL:           w_imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                                         instr[20], instr[30:21], 1'b0};
            default:          w_imm32 = {{20{instr[31]}}, instr[31:20]};
        endcase
    end

    assign imm = XLEN'($signed(w_imm32));

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : Instruction decode, operand forwarding, load-use detection
//               and the valid-tagged ID/EX pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage
    import rv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int FWD_EN  = 1,
    parameter int MEXT_EN = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [31:0]     id_instr,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] rf_rs1_data,
    input  logic [XLEN-1:0] rf_rs2_data,
    input  logic            ex_stall,
    input  logic            flush,
    input  logic            mem_valid,
    input  logic            mem_reg_we,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_result,
    input  logic            wb_valid,
    input  logic            wb_reg_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_result,
    output logic            id_stall,
    output logic            ex_valid,
    output logic [31:0]     ex_instr,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1_addr,
    output logic [4:0]      ex_rs2_addr,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic            ex_op1_src,
    output logic            ex_op2_src,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic [1:0]      ex_wb_src,
    output logic            ex_reg_we,
    output logic [4:0]      ex_rd,
    output logic            ex_illegal
);

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [4:0]      w_rd;
    logic [4:0]      w_rs1_addr;
    logic [4:0]      w_rs2_addr;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;
    logic            w_uses_rs2;
    logic            w_legal;
    logic            w_load_use;
    logic            w_bubble;
    idex_ctrl_t      w_ctrl;

    logic            r_valid;
    logic [31:0]     r_instr;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_imm;
    logic [4:0]      r_rs1_addr;
    logic [4:0]      r_rs2_addr;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [4:0]      r_rd;
    idex_ctrl_t      r_ctrl;

    assign w_opcode   = id_instr[6:0];
    assign w_rd       = id_instr[11:7];
    assign w_funct3   = id_instr[14:12];
    assign w_funct7   = id_instr[31:25];
    assign w_rs2_addr = id_instr[24:20];

    imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .instr (id_instr),
        .imm   (w_imm)
    );

    always_comb begin
        w_ctrl         = CTRL_BUBBLE;
        w_ctrl.op2_src = (w_opcode != OP_R);
        w_legal        = 1'b1;
        w_uses_rs2     = 1'b0;
        w_rs1_addr     = id_instr[19:15];
        case (w_opcode)
            OP_R: begin
                w_uses_rs2    = 1'b1;
                w_ctrl.reg_we = 1'b1;
                if (w_funct7 == 7'b0000000)
                    w_legal = 1'b1;
                else if (w_funct7 == 7'b0100000)
                    w_legal = (w_funct3 == 3'b000) || (w_funct3 == 3'b101);
                else if (w_funct7 == 7'b0000001)
                    w_legal = (MEXT_EN != 0);
                else
                    w_legal = 1'b0;
            end
            OP_I: begin
                w_ctrl.reg_we = 1'b1;
                // RV64 shift amounts take bit 25, so only funct6 is checked there.
                if (w_funct3 == 3'b001)
                    w_legal = (XLEN == 64) ? (id_instr[31:26] == 6'b000000)
                                           : (w_funct7 == 7'b0000000);
                else if (w_funct3 == 3'b101)
                    w_legal = (XLEN == 64)
                        ? ((id_instr[31:26] == 6'b000000) || (id_instr[31:26] == 6'b010000))
                        : ((w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000));
            end
            OP_L: begin
                w_ctrl.reg_we   = 1'b1;
                w_ctrl.mem_read = 1'b1;
                w_ctrl.wb_src   = WB_MEM;
                case (w_funct3)
                    3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
                    3'b011, 3'b110:                         w_legal = (XLEN == 64);
                    default:                                w_legal = 1'b0;
                endcase
            end
            OP_S: begin
                w_uses_rs2       = 1'b1;
                w_ctrl.mem_write = 1'b1;
                case (w_funct3)
                    3'b000, 3'b001, 3'b010: w_legal = 1'b1;
                    3'b011:                 w_legal = (XLEN == 64);
                    default:                w_legal = 1'b0;
                endcase
            end
            OP_B: begin
                w_uses_rs2     = 1'b1;
                w_ctrl.op1_src = 1'b1;
                w_legal        = (w_funct3 != 3'b010) && (w_funct3 != 3'b011);
            end
            OP_LUI: begin
                w_ctrl.reg_we = 1'b1;
                w_rs1_addr    = 5'd0;
            end
            OP_AUIPC: begin
                w_ctrl.reg_we  = 1'b1;
                w_ctrl.op1_src = 1'b1;
            end
            OP_JAL: begin
                w_ctrl.reg_we  = 1'b1;
                w_ctrl.op1_src = 1'b1;
                w_ctrl.wb_src  = WB_PC;
            end
            OP_JALR: begin
                w_ctrl.reg_we = 1'b1;
                w_ctrl.wb_src = WB_PC;
                w_legal       = (w_funct3 == 3'b000);
            end
            default: w_legal = 1'b0;
        endcase
        // An illegal instruction travels as valid but with no side effects.
        if (!w_legal) begin
            w_ctrl.reg_we    = 1'b0;
            w_ctrl.mem_read  = 1'b0;
            w_ctrl.mem_write = 1'b0;
            w_ctrl.illegal   = 1'b1;
        end
        if (w_rd == 5'd0)
            w_ctrl.reg_we = 1'b0;
    end

    if (FWD_EN != 0) begin : g_fwd
        always_comb begin
            w_rs1_data = rf_rs1_data;
            if (w_rs1_addr == 5'd0)
                w_rs1_data = '0;
            else if (mem_valid && mem_reg_we && (mem_rd == w_rs1_addr))
                w_rs1_data = mem_result;
            else if (wb_valid && wb_reg_we && (wb_rd == w_rs1_addr))
                w_rs1_data = wb_result;
        end
        always_comb begin
            w_rs2_data = rf_rs2_data;
            if (w_rs2_addr == 5'd0)
                w_rs2_data = '0;
            else if (mem_valid && mem_reg_we && (mem_rd == w_rs2_addr))
                w_rs2_data = mem_result;
            else if (wb_valid && wb_reg_we && (wb_rd == w_rs2_addr))
                w_rs2_data = wb_result;
        end
    end else begin : g_nofwd
        assign w_rs1_data = rf_rs1_data;
        assign w_rs2_data = rf_rs2_data;
    end

    assign w_load_use = id_valid && r_valid && r_ctrl.mem_read && (r_rd != 5'd0) &&
                        ((r_rd == w_rs1_addr) || ((r_rd == w_rs2_addr) && w_uses_rs2));
    assign id_stall   = w_load_use;

    // A bubble replaces ID/EX unless EX is stalled; flush overrides the stall.
    assign w_bubble = flush || (!ex_stall && (w_load_use || !id_valid));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_instr    <= NOP_INSTR;
            r_pc       <= '0;
            r_imm      <= '0;
            r_rs1_addr <= 5'd0;
            r_rs2_addr <= 5'd0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_rd       <= 5'd0;
            r_ctrl     <= CTRL_BUBBLE;
        end else if (w_bubble) begin
            r_valid    <= 1'b0;
            r_instr    <= NOP_INSTR;
            r_imm      <= '0;
            r_rs1_addr <= 5'd0;
            r_rs2_addr <= 5'd0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_rd       <= 5'd0;
            r_ctrl     <= CTRL_BUBBLE;
        end else if (!ex_stall) begin
            r_valid    <= 1'b1;
            r_instr    <= id_instr;
            r_pc       <= id_pc;
            r_imm      <= w_imm;
            r_rs1_addr <= w_rs1_addr;
            r_rs2_addr <= w_rs2_addr;
            r_rs1_data <= w_rs1_data;
            r_rs2_data <= w_rs2_data;
            r_rd       <= w_rd;
            r_ctrl     <= w_ctrl;
        end
    end

    assign ex_valid     = r_valid;
    assign ex_instr     = r_instr;
    assign ex_pc        = r_pc;
    assign ex_imm       = r_imm;
    assign ex_rs1_addr  = r_rs1_addr;
    assign ex_rs2_addr  = r_rs2_addr;
    assign ex_rs1_data  = r_rs1_data;
    assign ex_rs2_data  = r_rs2_data;
    assign ex_op1_src   = r_ctrl.op1_src;
    assign ex_op2_src   = r_ctrl.op2_src;
    assign ex_mem_read  = r_ctrl.mem_read;
    assign ex_mem_write = r_ctrl.mem_write;
    assign ex_wb_src    = r_ctrl.wb_src;
    assign ex_reg_we    = r_ctrl.reg_we;
    assign ex_rd        = r_rd;
    assign ex_illegal   = r_ctrl.illegal && r_valid;

endmodule
`default_nettype wire
